// File: rtl/bcd_multi_digit_counter.sv
// Multi-digit BCD up/down counter with IDLE/RUN/EXPIRED control and a one-cycle expiry pulse.
// Optional BCD_LOAD_CLAMP_EN: clamp out-of-range load digits to their digit max.
module bcd_digit_step #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] i_d,
  input  logic       i_cin,
  input  logic       i_up,
  output logic [3:0] o_d,
  output logic       o_cout
);
  // Illegal digits (> MAX) roll to 0 with carry when counting up; a down step
  // is a plain decrement and borrows only once the digit reaches 0.
  always_comb begin
    o_d    = i_d;
    o_cout = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_d >= MAX) begin
          o_d    = 4'd0;
          o_cout = 1'b1;
        end else begin
          o_d = i_d + 4'd1;
        end
      end else begin
        if (i_d == 4'd0) begin
          o_d    = MAX;
          o_cout = 1'b1;
        end else begin
          o_d = i_d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_multi_digit_counter #(
  parameter int DIGITS = 4,
  parameter int MM_SS  = 0,
  parameter int WRAP   = 0
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                ena,
  input  logic                ena_cnt,
  input  logic                up_dn,
  input  logic                start,
  input  logic                stop,
  input  logic                loadN,
  input  logic [4*DIGITS-1:0] datain,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                running,
  output logic                expired
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_count;
  logic                r_expired;

  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_max_val;
  logic [4*DIGITS-1:0] w_load_val;
  logic [4*DIGITS-1:0] w_end_val;
  logic [DIGITS:0]     w_carry;
  logic                w_at_end;
  logic                w_next_end;
  logic                w_tick;

  assign w_carry[0] = 1'b1;

  // Carry/borrow ripples through the whole digit chain within one cycle.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    localparam logic [3:0] DMAX = (MM_SS != 0 && gi == 1) ? 4'd5 : 4'd9;
    bcd_digit_step #(.MAX(DMAX)) u_step (
      .i_d    (r_count[4*gi +: 4]),
      .i_cin  (w_carry[gi]),
      .i_up   (up_dn),
      .o_d    (w_next[4*gi +: 4]),
      .o_cout (w_carry[gi+1])
    );
    assign w_max_val[4*gi +: 4] = DMAX;
`ifdef BCD_LOAD_CLAMP_EN
    assign w_load_val[4*gi +: 4] = (datain[4*gi +: 4] > DMAX) ? DMAX : datain[4*gi +: 4];
`else
    assign w_load_val[4*gi +: 4] = datain[4*gi +: 4];
`endif
  end

  assign w_end_val  = up_dn ? w_max_val : '0;
  assign w_at_end   = (r_count == w_end_val);
  assign w_next_end = (w_next == w_end_val);
  assign w_tick     = ena & ena_cnt & (r_state == RUN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (!loadN) begin
        r_count <= w_load_val;
        if (r_state == EXPIRED) r_state <= IDLE;
      end else if (stop) begin
        if (r_state == RUN) r_state <= IDLE;
      end else if (start) begin
        if (r_state != RUN) r_state <= RUN;
      end else if (w_tick) begin
        // Without wrap, a tick at the end value re-expires in place.
        if (WRAP == 0 && w_at_end) begin
          r_expired <= 1'b1;
          r_state   <= EXPIRED;
        end else begin
          r_count <= w_next;
          if (w_next_end) begin
            r_expired <= 1'b1;
            if (WRAP == 0) r_state <= EXPIRED;
          end
        end
      end
    end
  end

  assign count   = r_count;
  assign tc      = w_at_end;
  assign running = (r_state == RUN);
  assign expired = r_expired;
endmodule

// File: doc/bcd_multi_digit_counter.md
Name: bcd_multi_digit_counter

Overview:
- Parametrised multi-digit BCD up/down counter. Successor to the single-digit decimal down counter.
- Feeds the on-screen score/timer digit renderers. Per-digit BCD nibbles drive the digit-bitmap selectors directly.
- Adds:
  - digit count and direction control;
  - optional mm:ss mode (tens-of-seconds digit modulo 6);
  - wrap or saturate at the end of the range;
  - run/expired state machine with a one-cycle expiry pulse.

Parameters:
- DIGITS, 4, number of BCD digits (1..8). Digit 0 is the least significant.
- MM_SS, 0, 1 = digit 1 counts 0..5 (seconds tens). Requires DIGITS >= 2.
- WRAP, 0, 0 = stop at the range end and enter EXPIRED. 1 = wrap around and keep running.

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- ena  in  1  count tick (e.g. 1 Hz strobe, one clk wide)
- ena_cnt  in  1  count gate (game not paused)
- up_dn  in  1  1 = count up, 0 = count down. Sampled on every tick.
- start  in  1  pulse: IDLE/EXPIRED -> RUN
- stop  in  1  pulse: RUN -> IDLE, value held
- loadN  in  1  active-low synchronous load
- datain  in  4*DIGITS  packed BCD load value, digit 0 in [3:0]
- count  out  4*DIGITS  packed BCD current value
- tc  out  1  combinational: count at range end for current direction (all-zero when down, all-max when up)
- running  out  1  state == RUN
- expired  out  1  one-clk pulse on reaching the range end while in RUN

Behaviour:
- Reset state: count = 0, state = IDLE, expired = 0.
- Digit max: 5 for digit 1 when MM_SS = 1, else 9.
- States: IDLE, RUN, EXPIRED.
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. Range end reached with WRAP = 0 -> EXPIRED.
  - EXPIRED: start -> RUN. loadN low -> IDLE.
- Priority per cycle: resetN > loadN > stop > start > tick.
  - loadN low: count <= datain. In RUN, state is kept.
  - A tick coinciding with a load is ignored.
- Tick: ena & ena_cnt & state == RUN. Takes effect on the next clk edge, latency 1.
- Down tick:
  - Digit 0 decrements.
  - A digit at 0 becomes its max and borrows into the next digit.
  - Borrow ripples combinationally in the same cycle.
- Up tick:
  - Digit 0 increments.
  - A digit at its max becomes 0 and carries into the next digit.
- Range end: the tick transition from the last non-end value to the end value (0..0 when down, max..max when up).
  - Pulse expired for 1 clk on the edge where count becomes the end value.
  - WRAP = 0: count holds at the end value, state -> EXPIRED, further ticks ignored.
  - WRAP = 1: stays in RUN. The next tick wraps (0..0 -> max..max when down, max..max -> 0..0 when up) with normal borrow/carry. No second expired pulse is issued for the wrap itself.
- Start while count is already at the range end:
  - WRAP = 0: enters RUN, then the first tick re-expires immediately (count unchanged, expired pulse, -> EXPIRED).
  - WRAP = 1: the first tick wraps.
- Direction change mid-run: legal and takes effect on the next tick. expired fires only on a tick landing on the end value for the direction sampled on that tick.
- Async reset mid-count: count, state and expired clear immediately.
- Invalid BCD digits (>9, or >5 in MM_SS digit 1): handling per the optional feature.
- tc = count equals all-zero (up_dn = 0) or all-max (up_dn = 1). Purely combinational, independent of state.

Optional Feature:
- Macro: BCD_LOAD_CLAMP_EN.
- Defined: on load, each datain digit above its digit max is stored as its digit max. count always holds legal BCD.
- Undefined: datain is stored unmodified.
  - Up tick on an illegal digit: digit becomes 0 with carry.
  - Down tick on an illegal digit: plain binary decrement, no borrow until the digit reaches 0.

Test Plan:
- Reset, load 0x0003, start, down ticks (DIGITS=4, WRAP=0) -> 0002, 0001, 0000 with expired high for 1 clk, running=0, further ticks keep 0000.
- Load 0x0100, start, 1 down tick -> 0x0099, borrow across two digits, tc=0. MM_SS=1: load 0x0100, 1 down tick -> 0x0059.
- WRAP=1, up_dn=1, load 0x9998, start, 3 ticks -> 9999 (expired pulse), 0000, 0001, no extra pulse.
- Tick with ena_cnt=0 or in IDLE -> count unchanged. Stop mid-run then 2 ticks -> held. Start -> counting resumes.
- loadN low on the same edge as a tick with datain 0x0042 -> count 0x0042, no decrement. Async resetN low mid-run -> count 0, running 0 without waiting for a clock edge.
- Load digit value 0xC into digit 0 -> 0x9 stored with BCD_LOAD_CLAMP_EN defined, 0xC stored without. Without the macro, the next up tick -> digit 0 = 0 with carry.
